// File: rtl/limbus_sysid_regs.sv
// System-identification register bank on the limbus Avalon-MM fabric with fixed one-cycle read latency.
// Optional feature macro: LIMBUS_SYSID_UPTIME_EN adds the 64-bit uptime counter and its coherent high-word snapshot.
module limbus_sysid_regs #(
    parameter logic [31:0] SYS_ID    = 32'h0,
    parameter logic [31:0] TIMESTAMP = 32'h0,
    parameter int          NUM_USER  = 2,
    parameter int          ADDR_W    = 4
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic [ADDR_W-1:0]                                 address,
    input  logic                                              read,
    input  logic                                              write,
    input  logic [31:0]                                       writedata,
    output logic [31:0]                                       readdata,
    output logic                                              readdatavalid,
    input  logic [((NUM_USER > 0) ? 32*NUM_USER : 1)-1:0]     user_status
);

    localparam logic [31:0] ADDR_ID      = 32'd0;
    localparam logic [31:0] ADDR_TS      = 32'd1;
    localparam logic [31:0] ADDR_UP_LO   = 32'd2;
    localparam logic [31:0] ADDR_UP_HI   = 32'd3;
    localparam logic [31:0] ADDR_SCRATCH = 32'd4;
    localparam logic [31:0] ADDR_CAPS    = 32'd5;
    localparam logic [31:0] ADDR_USER0   = 32'd6;

    logic [31:0] word_idx;
    logic [31:0] scratch;
    logic [31:0] uptime_lo;
    logic [31:0] uptime_hi_word;
    logic [31:0] caps_word;
    logic [31:0] rd_mux;
    logic        lo_read;

    assign word_idx = 32'(address);
    assign lo_read  = read && (word_idx == ADDR_UP_LO);

`ifdef LIMBUS_SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;

    logic [63:0] uptime_cnt;
    logic [31:0] uptime_snap;

    // The LO read latches the live high word so a following HI read is coherent with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            uptime_cnt  <= 64'h0;
            uptime_snap <= 32'h0;
        end else begin
            uptime_cnt <= uptime_cnt + 64'h1;
            if (lo_read) begin
                uptime_snap <= uptime_cnt[63:32];
            end
        end
    end

    assign uptime_lo      = uptime_cnt[31:0];
    assign uptime_hi_word = uptime_snap;
`else
    localparam logic UPTIME_PRESENT = 1'b0;

    assign uptime_lo      = 32'h0;
    assign uptime_hi_word = 32'h0;
`endif

    assign caps_word = {16'h0, 7'h0, UPTIME_PRESENT, 8'(NUM_USER)};

    // NOTE: rd_mux gets its default first, so every path assigns it and no latch is inferred.
    always_comb begin
        rd_mux = 32'h0;
        if (word_idx == ADDR_ID) begin
            rd_mux = SYS_ID;
        end else if (word_idx == ADDR_TS) begin
            rd_mux = TIMESTAMP;
        end else if (word_idx == ADDR_UP_LO) begin
            rd_mux = uptime_lo;
        end else if (word_idx == ADDR_UP_HI) begin
            rd_mux = uptime_hi_word;
        end else if (word_idx == ADDR_SCRATCH) begin
            rd_mux = scratch;
        end else if (word_idx == ADDR_CAPS) begin
            rd_mux = caps_word;
        end
        for (int k = 0; k < NUM_USER; k++) begin
            if (word_idx == ADDR_USER0 + 32'(k)) begin
                rd_mux = user_status[32*k +: 32];
            end
        end
    end

    // NOTE: non-blocking assignments let a same-cycle read return the pre-write scratch value.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata      <= 32'h0;
            readdatavalid <= 1'b0;
            scratch       <= 32'h0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_mux;
            end
            if (write && (word_idx == ADDR_SCRATCH)) begin
                scratch <= writedata;
            end
        end
    end

endmodule

// File: tb/tb_limbus_sysid_regs.sv
// Self-checking bench for limbus_sysid_regs: directed register-map cases plus randomized traffic against a reference model.
// Expectations follow LIMBUS_SYSID_UPTIME_EN when it is defined for the build.
module tb_limbus_sysid_regs;

    localparam logic [31:0] SYS_ID    = 32'h5462_0B5A;
    localparam logic [31:0] TIMESTAMP = 32'd1415787354;
    localparam int          NUM_USER  = 2;
    localparam int          ADDR_W    = 4;

`ifdef LIMBUS_SYSID_UPTIME_EN
    localparam bit          UPTIME_ON = 1'b1;
    localparam logic [31:0] CAPS_EXP  = 32'h0000_0102;
`else
    localparam bit          UPTIME_ON = 1'b0;
    localparam logic [31:0] CAPS_EXP  = 32'h0000_0002;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] address = '0;
    logic              read = 1'b0;
    logic              write = 1'b0;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic              readdatavalid;
    logic [63:0]       user_status = '0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: uptime is derived from the edge count since the last reset edge.
    longint      edge_no   = 0;
    longint      rst_edge  = 0;
    logic [31:0] m_scratch = '0;
    logic [31:0] m_snap    = '0;
    logic [31:0] m_held    = '0;
    logic [31:0] last_rdata;

    limbus_sysid_regs #(
        .SYS_ID   (SYS_ID),
        .TIMESTAMP(TIMESTAMP),
        .NUM_USER (NUM_USER),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .user_status  (user_status)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_uptime();
        return 64'(edge_no - rst_edge - 1);
    endfunction

    function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] a);
        logic [63:0] up;
        up = model_uptime();
        case (int'(a))
            0:       return SYS_ID;
            1:       return TIMESTAMP;
            2:       return UPTIME_ON ? up[31:0] : 32'h0;
            3:       return UPTIME_ON ? m_snap : 32'h0;
            4:       return m_scratch;
            5:       return CAPS_EXP;
            6:       return user_status[31:0];
            7:       return user_status[63:32];
            default: return 32'h0;
        endcase
    endfunction

    // One bus cycle, entered and left on a falling edge; checks the response one edge later.
    task automatic bus_cycle(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                             input logic [31:0] wd);
        logic [31:0] exp;
        logic [63:0] up;
        exp       = model_read(a);
        up        = model_uptime();
        reset     = 1'b0;
        read      = rd;
        write     = wr;
        address   = a;
        writedata = wd;
        @(posedge clock);
        edge_no++;
        if (rd && (int'(a) == 2)) m_snap = up[63:32];
        if (wr && (int'(a) == 4)) m_scratch = wd;
        if (rd) m_held = exp;
        @(negedge clock);
        read  = 1'b0;
        write = 1'b0;
        last_rdata = readdata;
        check($sformatf("rdv@%0d", a), {31'h0, readdatavalid}, {31'h0, rd});
        check(rd ? $sformatf("rdata@%0d", a) : "rdata_hold", readdata, m_held);
    endtask

    task automatic reset_cycle(input bit rd);
        reset   = 1'b1;
        read    = rd;
        write   = 1'b0;
        address = '0;
        @(posedge clock);
        rst_edge  = edge_no;
        edge_no++;
        m_scratch = '0;
        m_snap    = '0;
        m_held    = '0;
        @(negedge clock);
        read = 1'b0;
        check("rst_rdv", {31'h0, readdatavalid}, 32'h0);
        check("rst_rdata", readdata, 32'h0);
    endtask

    initial begin
        @(negedge clock);
        reset_cycle(1'b0);
        reset_cycle(1'b0);

        bus_cycle(1, 0, 4'd0, '0);  check("id", last_rdata, 32'h5462_0B5A);
        bus_cycle(1, 0, 4'd1, '0);  check("timestamp", last_rdata, 32'd1415787354);
        bus_cycle(1, 0, 4'd5, '0);  check("caps", last_rdata, CAPS_EXP);
        bus_cycle(0, 0, 4'd0, '0);

        bus_cycle(0, 1, 4'd4, 32'hDEAD_BEEF);
        bus_cycle(1, 0, 4'd4, '0);  check("scratch_rb", last_rdata, 32'hDEAD_BEEF);
        reset_cycle(1'b1);
        bus_cycle(1, 0, 4'd4, '0);  check("scratch_rst", last_rdata, 32'h0);
        bus_cycle(0, 1, 4'd0, 32'hFFFF_0000);
        bus_cycle(1, 0, 4'd0, '0);  check("id_ro", last_rdata, 32'h5462_0B5A);

        user_status = {32'hA5A5_0001, 32'h1234_5678};
        bus_cycle(1, 0, 4'd6, '0);  check("user0", last_rdata, 32'h1234_5678);
        bus_cycle(1, 0, 4'd7, '0);  check("user1", last_rdata, 32'hA5A5_0001);
        bus_cycle(1, 0, 4'd15, '0); check("unmapped", last_rdata, 32'h0);

        bus_cycle(0, 1, 4'd4, 32'h1);
        bus_cycle(1, 1, 4'd4, 32'h2); check("rw_old", last_rdata, 32'h1);
        bus_cycle(1, 0, 4'd4, '0);    check("rw_new", last_rdata, 32'h2);

        bus_cycle(1, 0, 4'd2, '0);
        bus_cycle(0, 0, 4'd0, '0);
        bus_cycle(1, 0, 4'd3, '0);
        if (!UPTIME_ON) begin
            bus_cycle(1, 0, 4'd2, '0); check("up_lo_absent", last_rdata, 32'h0);
            bus_cycle(1, 0, 4'd3, '0); check("up_hi_absent", last_rdata, 32'h0);
        end

        for (int i = 0; i < 400; i++) begin
            user_status = {$urandom, $urandom};
            if ($urandom_range(0, 49) == 0) begin
                reset_cycle(1'($urandom_range(0, 1)));
            end else begin
                bus_cycle(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
                          ADDR_W'($urandom_range(0, 15)), $urandom);
            end
        end

`ifdef LIMBUS_SYSID_UPTIME_EN
        // Preload the counter just below a high-word carry; the model is not used past this point.
        force dut.uptime_cnt = 64'h0000_0001_FFFF_FFFF;
        read    = 1'b1;
        address = 4'd2;
        @(posedge clock);
        #1 release dut.uptime_cnt;
        @(negedge clock);
        read = 1'b0;
        check("force_lo", readdata, 32'hFFFF_FFFF);
        @(negedge clock);
        read    = 1'b1;
        address = 4'd3;
        @(negedge clock);
        read = 1'b0;
        check("force_hi_snap", readdata, 32'h0000_0001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
